// File: rtl/fifo_unpacker.sv
// Pops one wide FIFO entry and replays it as 1..RATIO narrow beats, LSB beat first.
// The final beat of one entry overlaps the load of the next, so a steady stream has no bubbles.
module fifo_unpacker #(
    parameter int  OUT_DW = 8,
    parameter int  RATIO  = 4,
    localparam int IN_DW  = OUT_DW * RATIO,
    localparam int CW     = $clog2(RATIO + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [IN_DW-1:0]  in_data,
    input  logic [CW-1:0]     in_nbeats,
    input  logic              in_valid,
    output logic              in_pop,
    output logic [OUT_DW-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready
);
    localparam int BW = $clog2(RATIO);

    typedef enum logic {
        EMPTY = 1'b0,
        BUSY  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IN_DW-1:0] word_q, word_d;
    logic [BW-1:0]    beat_cnt_q, beat_cnt_d;
    logic [CW-1:0]    nbeats_q, nbeats_d;
    logic [CW-1:0]    nbeats_norm;
    logic             acc;

    assign out_valid = (state_q == BUSY);
    assign out_data  = word_q[int'(beat_cnt_q) * OUT_DW +: OUT_DW];
    assign out_last  = out_valid && (CW'(beat_cnt_q) == nbeats_q - CW'(1));
    assign acc       = out_valid && out_ready;

    // Gated by rst so the FIFO is never popped while this block is held in reset.
    assign in_pop = in_valid && !flush && !rst && (!out_valid || (acc && out_last));

    // A beat count of zero or beyond RATIO means a full entry.
    assign nbeats_norm = (in_nbeats == '0 || in_nbeats > CW'(RATIO)) ? CW'(RATIO) : in_nbeats;

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        beat_cnt_d = beat_cnt_q;
        nbeats_d   = nbeats_q;
        if (flush) begin
            state_d    = EMPTY;
            beat_cnt_d = '0;
        end else if (in_pop) begin
            state_d    = BUSY;
            word_d     = in_data;
            beat_cnt_d = '0;
            nbeats_d   = nbeats_norm;
        end else if (acc && !out_last) begin
            beat_cnt_d = beat_cnt_q + BW'(1);
        end else if (acc && out_last) begin
            state_d    = EMPTY;
            beat_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            word_q     <= '0;
            beat_cnt_q <= '0;
            nbeats_q   <= '0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            beat_cnt_q <= beat_cnt_d;
            nbeats_q   <= nbeats_d;
        end
    end

    assert property (@(posedge clk) disable iff (rst) in_pop |-> in_valid);

    // A stalled beat must not change unless a flush discards it.
    assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready && !flush) |=> ($stable(out_data) && $stable(out_last)));

endmodule
